// File: rtl/sa_feed_ctrl.sv
// sa_feed_ctrl: reads K operand vectors, skews them per lane and steps them into the systolic array on each shift.
module sa_feed_ctrl #(
    parameter int D_W   = 16,
    parameter int SA_R  = 16,
    parameter int SA_C  = 16,
    parameter int K_MAX = 64,
    parameter int A_W   = 6
) (
    input  logic                 I_CLK,
    input  logic                 I_ASYN_RST,
    input  logic                 I_START,
    input  logic                 I_ABORT,
    input  logic [A_W:0]         I_K,
    output logic                 O_RD_EN,
    output logic [A_W-1:0]       O_RADDR,
    input  logic [SA_R*D_W-1:0]  I_X_COL,
    input  logic [SA_C*D_W-1:0]  I_W_ROW,
    output logic [SA_R*D_W-1:0]  O_X,
    output logic [SA_C*D_W-1:0]  O_W,
    output logic                 O_SA_START,
    output logic                 O_SA_END,
    input  logic                 I_SHIFT,
    output logic                 O_BUSY,
    output logic                 O_DONE
);
    localparam int S_W = $clog2(K_MAX + SA_R + SA_C);
    localparam logic [A_W:0] KM = K_MAX[A_W:0];
    localparam logic [S_W-1:0] EXT = S_W'(SA_R + SA_C - 3);

    typedef enum logic [2:0] {IDLE, LOAD, CAPT, FEED, END} st_t;
    st_t st;
    logic [S_W-1:0] s, k_q, k_in, s_nx;
    logic abrt, clr, cap, fresh;

    assign k_in  = S_W'((I_K > KM) ? KM : I_K);
    assign s_nx  = s + S_W'(1);
    assign abrt  = I_ABORT && (st == LOAD || st == CAPT || st == FEED);
    assign clr   = (st == IDLE && I_START) || abrt;
    assign cap   = st == CAPT && !I_ABORT;
    assign fresh = s < k_q;

    always_ff @(posedge I_CLK or posedge I_ASYN_RST) begin
        if (I_ASYN_RST) begin
            st         <= IDLE;
            s          <= '0;
            k_q        <= '0;
            O_RD_EN    <= 1'b0;
            O_RADDR    <= '0;
            O_SA_START <= 1'b0;
            O_SA_END   <= 1'b0;
            O_BUSY     <= 1'b0;
            O_DONE     <= 1'b0;
        end else begin
            O_RD_EN    <= 1'b0;
            O_SA_START <= 1'b0;
            O_SA_END   <= 1'b0;
            O_DONE     <= 1'b0;
            if (abrt) begin
                st       <= END;
                O_SA_END <= 1'b1;
            end else begin
                case (st)
                    IDLE: if (I_START) begin
                        if (k_in != '0) begin
                            st      <= LOAD;
                            k_q     <= k_in;
                            s       <= '0;
                            O_BUSY  <= 1'b1;
                            O_RD_EN <= 1'b1;
                            O_RADDR <= '0;
                        end else
                            O_DONE <= 1'b1;
                    end
                    LOAD: st <= CAPT;
                    CAPT: begin
                        st         <= FEED;
                        O_SA_START <= s == '0;
                    end
                    FEED: if (I_SHIFT) begin
                        if (s == k_q + EXT) begin
                            st       <= END;
                            O_SA_END <= 1'b1;
                            O_DONE   <= 1'b1;
                        end else begin
                            st      <= LOAD;
                            s       <= s_nx;
                            O_RD_EN <= s_nx < k_q;
                            O_RADDR <= s_nx[A_W-1:0];
                        end
                    end
                    END: begin
                        st     <= IDLE;
                        O_BUSY <= 1'b0;
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end

    genvar i, j;
    for (i = 0; i < SA_R; i++) begin : g_x
        logic [D_W-1:0] ch [i+1];
        always_ff @(posedge I_CLK or posedge I_ASYN_RST) begin
            if (I_ASYN_RST || clr) begin
                for (int d = 0; d <= i; d++) ch[d] <= '0;
            end else if (cap) begin
                ch[0] <= fresh ? I_X_COL[i*D_W +: D_W] : '0;
                for (int d = i; d > 0; d--) ch[d] <= ch[d-1];
            end
        end
        assign O_X[i*D_W +: D_W] = ch[i];
    end
    for (j = 0; j < SA_C; j++) begin : g_w
        logic [D_W-1:0] ch [j+1];
        always_ff @(posedge I_CLK or posedge I_ASYN_RST) begin
            if (I_ASYN_RST || clr) begin
                for (int d = 0; d <= j; d++) ch[d] <= '0;
            end else if (cap) begin
                ch[0] <= fresh ? I_W_ROW[j*D_W +: D_W] : '0;
                for (int d = j; d > 0; d--) ch[d] <= ch[d-1];
            end
        end
        assign O_W[j*D_W +: D_W] = ch[j];
    end
endmodule
